result_bcd_encoder: RTL and testbench

- Converts the calculator ALU's 32-bit two's-complement result back into the signed-BCD word format the keypad front end produces, for the display path.
- Word format: bits [31:28] = 4'hF for negative, 4'h0 for non-negative; bits [27:0] = 7 BCD magnitude digits, with the least significant digit in [3:0].
- Conversion is iterative double-dabble (one shift per clock), with a valid/ready handshake on the input and a one-cycle result strobe on the output.

---
 rtl/result_bcd_encoder.sv | 115 +++++++++++
 tb/tb_result_bcd_encoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_encoder.sv
// Two's-complement to signed-BCD converter (double-dabble, one shift per clock); result strobes 25 cycles after accept, 1 on overflow/error.
// Backpressure: in_ready is high only in IDLE; in_valid is ignored while busy, so upstream must hold its request.
module result_bcd_encoder #(
    parameter int MAG_DIGITS = 7,
    parameter int CONV_BITS  = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_error,
    output logic        in_ready,
    output logic [31:0] bcd_out,
    output logic        overflow,
    output logic        out_valid
);

    localparam int BCD_W = 4 * MAG_DIGITS;
    localparam int SR_W  = BCD_W + CONV_BITS;
    localparam int CNT_W = $clog2(CONV_BITS);
    localparam logic [32:0] MAX_MAG = 33'(10**MAG_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, PREP, CONV, DONE} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_in_data;
    logic              r_in_error;
    logic              r_sign;
    logic [SR_W-1:0]   r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_bcd;
    logic              r_ovf;

    logic [32:0]       w_mag;
    logic              w_reject;
    logic              w_last;
    logic [SR_W-1:0]   w_adj;
    logic [SR_W-1:0]   w_shifted;

    // 33-bit negate so -2^31 yields +2^31 instead of wrapping to itself
    assign w_mag    = r_in_data[31] ? (33'd0 - {1'b1, r_in_data}) : {1'b0, r_in_data};
    assign w_reject = r_in_error || (w_mag > MAX_MAG);
    assign w_last   = (r_cnt == CNT_W'(CONV_BITS - 1));

    always_comb begin
        w_adj = r_shift;
        for (int d = 0; d < MAG_DIGITS; d++) begin
            if (r_shift[CONV_BITS + 4*d +: 4] >= 4'd5)
                w_adj[CONV_BITS + 4*d +: 4] = r_shift[CONV_BITS + 4*d +: 4] + 4'd3;
        end
        w_shifted = {w_adj[SR_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = PREP;
            PREP:    w_next_state = w_reject ? DONE : CONV;
            CONV:    if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_data  <= '0;
            r_in_error <= 1'b0;
            r_sign     <= 1'b0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_data  <= in_data;
                        r_in_error <= in_error;
                    end
                end
                PREP: begin
                    r_sign  <= r_in_data[31];
                    r_shift <= {{BCD_W{1'b0}}, w_mag[CONV_BITS-1:0]};
                    r_cnt   <= '0;
                    if (w_reject) begin
                        r_bcd <= '0;
                        r_ovf <= 1'b1;
                    end
                end
                CONV: begin
                    r_shift <= w_shifted;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bcd <= {(r_sign ? 4'hF : 4'h0), w_shifted[SR_W-1 -: BCD_W]};
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign bcd_out   = r_bcd;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_result_bcd_encoder.sv
// Bench for result_bcd_encoder: fixed vector table, hand-written busy/reset sequences, randomized runs vs an arithmetic model.
module tb_result_bcd_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_error;
    logic        in_ready;
    logic [31:0] bcd_out;
    logic        overflow;
    logic        out_valid;

    int n_pass  = 0;
    int n_total = 0;

    result_bcd_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_error  (in_error),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [31:0] exp_bcd;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: plain decimal arithmetic on the signed value
    task automatic model(input logic [31:0] d, input logic e,
                         output logic [31:0] bcd, output logic ovf, output int lat);
        longint v;
        longint mag;
        v   = longint'($signed(d));
        mag = (v < 0) ? -v : v;
        bcd = '0;
        if (e || mag > 64'sd9999999) begin
            ovf = 1'b1;
            lat = 1;
        end else begin
            ovf = 1'b0;
            lat = 25;
            for (int i = 0; i < 7; i++) begin
                bcd[4*i +: 4] = 4'(mag % 10);
                mag = mag / 10;
            end
            if (v < 0) bcd[31:28] = 4'hF;
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] d, input logic e,
                           input logic [31:0] exp_bcd, input logic exp_ovf,
                           input int exp_lat, input int intrude);
        int          n;
        int          busy_bad;
        int          hold_bad;
        logic [31:0] held_b;
        logic        held_o;
        @(negedge clk);
        check({tag, " ready_idle"}, 32'(in_ready), 32'd1);
        in_data  = d;
        in_error = e;
        in_valid = 1'b1;
        held_b   = bcd_out;
        held_o   = overflow;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_error = 1'b0;
        @(negedge clk);
        n = 0; busy_bad = 0; hold_bad = 0;
        while (!out_valid && n < 40) begin
            if (in_ready) busy_bad++;
            if (bcd_out !== held_b || overflow !== held_o) hold_bad++;
            if (intrude > 0 && n == intrude) begin
                in_data  = 32'd77;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " bcd_out"}, bcd_out, exp_bcd);
        check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
        check({tag, " ready_low_busy"}, 32'(busy_bad + int'(in_ready)), 32'd0);
        check({tag, " hold_before_done"}, 32'(hold_bad), 32'd0);
        @(negedge clk);
        check({tag, " strobe_one_cycle"}, 32'(out_valid), 32'd0);
        check({tag, " ready_after"}, 32'(in_ready), 32'd1);
        check({tag, " hold_after"}, bcd_out, exp_bcd);
    endtask

    vec_t vecs[9];

    initial begin
        logic [31:0] eb;
        logic        eo;
        int          el;
        int          strobes;
        logic [31:0] rd;
        logic        re;

        vecs[0] = '{32'd1234,        1'b0, 32'h0000_1234, 1'b0, 25};
        vecs[1] = '{32'hFFFF_FFFF,   1'b0, 32'hF000_0001, 1'b0, 25};
        vecs[2] = '{32'd0,           1'b0, 32'h0000_0000, 1'b0, 25};
        vecs[3] = '{32'd9999999,     1'b0, 32'h0999_9999, 1'b0, 25};
        vecs[4] = '{-32'sd9999999,   1'b0, 32'hF999_9999, 1'b0, 25};
        vecs[5] = '{32'd10000000,    1'b0, 32'h0000_0000, 1'b1, 1};
        vecs[6] = '{32'h8000_0000,   1'b0, 32'h0000_0000, 1'b1, 1};
        vecs[7] = '{32'd5,           1'b1, 32'h0000_0000, 1'b1, 1};
        vecs[8] = '{32'd42,          1'b0, 32'h0000_0042, 1'b0, 25};

        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_error = 1'b0;
        repeat (3) @(negedge clk);
        check("reset bcd_out", bcd_out, 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_one($sformatf("vec%0d", i), vecs[i].data, vecs[i].err,
                    vecs[i].exp_bcd, vecs[i].exp_ovf, vecs[i].exp_lat, 0);

        // Request of 77 arriving mid-conversion must be dropped
        run_one("busy1234", 32'd1234, 1'b0, 32'h0000_1234, 1'b0, 25, 8);
        strobes = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) strobes++;
        end
        check("busy no_second_result", 32'(strobes), 32'd0);

        // Reset 10 cycles into a conversion
        @(negedge clk);
        in_data = 32'd9876; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst bcd_out", bcd_out, 32'd0);
        check("midrst overflow", 32'(overflow), 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        strobes = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) strobes++;
        end
        check("midrst no_strobe", 32'(strobes), 32'd0);
        run_one("after_rst5", 32'd5, 1'b0, 32'h0000_0005, 1'b0, 25, 0);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       rd = $urandom;
                1:       rd = 32'($urandom_range(0, 9999999));
                2:       rd = -32'($urandom_range(0, 9999999));
                default: rd = 32'($urandom_range(9999990, 10000010));
            endcase
            re = ($urandom_range(0, 7) == 0);
            model(rd, re, eb, eo, el);
            run_one($sformatf("rand%0d_%h", k, rd), rd, re, eb, eo, el, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
